cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of functional-unit result sources.
REQ-002 SHALL have parameter DATA_W, default 64, result value width.
REQ-003 SHALL have parameter TAG_W, default 6, destination tag width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_SRC  source i holds a result.
REQ-007 SHALL have port req_data  input  NUM_SRC*DATA_W  result values, source i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_tag  input  NUM_SRC*TAG_W  destination tags, source i at bits [i*TAG_W +: TAG_W].
REQ-009 SHALL have port req_ready  output  NUM_SRC  one-hot grant; source i's result is consumed this cycle.
REQ-010 SHALL have port flush  input  1  squash all in-flight broadcast state.
REQ-011 SHALL have port out_ready  input  1  downstream 65-bit register wall accepts (drives its enable).
REQ-012 SHALL have port out_bus  output  DATA_W+1  {valid, value}; bit DATA_W is valid.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the broadcast on out_bus.

Function
REQ-014 SHALL hold one registered output entry (out_valid, value, tag); out_bus[DATA_W] = out_valid.
REQ-015 SHALL define accept = (!out_valid | out_ready) & !flush.
REQ-016 SHALL, when accept, grant the first i with req_valid[i] scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
REQ-017 SHALL drive req_ready combinationally: at most one bit set, only on the granted source, only when accept.
REQ-018 SHALL load the granted value and tag into the output entry on that edge and set out_valid; latency 1 cycle from grant to out_bus.
REQ-019 SHALL, on a grant to source g, set rr_ptr <= (g+1) mod NUM_SRC; rr_ptr unchanged otherwise.
REQ-020 SHALL, when accept and no req_valid set, clear out_valid on the edge (out_ready consumed entry, none replaces it).
REQ-021 SHALL, when out_valid & !out_ready & !flush, hold value, tag and out_valid stable and assert no req_ready.
REQ-022 SHALL, when flush, clear out_valid on the edge, assert no req_ready that cycle, leave rr_ptr unchanged; flush overrides out_ready and req_valid.
REQ-023 SHALL sustain one broadcast per cycle while out_ready stays high and requests are present.
REQ-024 SHALL guarantee no source with req_valid held high waits more than NUM_SRC-1 grants.
REQ-025 SHALL not alter value/tag bits when out_valid clears; only the valid bit is significant then.

Reset
REQ-026 SHALL, on reset high at a clock edge, set out_valid=0, value=0, tag=0, rr_ptr=0.
REQ-027 SHALL drive req_ready=0 in any cycle reset is high; reset overrides flush and all requests.
REQ-028 SHALL, on reset asserted mid-broadcast with out_ready low, discard the held entry; out_bus=0 next cycle.

Verification
REQ-029 SHALL verify: reset, then req_valid=4'b0001, data=0x1F, tag=3, out_ready=1 -> req_ready=4'b0001 same cycle; next cycle out_bus={1,0x1F}, out_tag=3.
REQ-030 SHALL verify: req_valid=4'b1111 held, out_ready=1, from reset -> grants 0,1,2,3,0 on consecutive cycles; out_bus valid every cycle.
REQ-031 SHALL verify: out_valid=1 with data 0xAB, out_ready=0 for 3 cycles, req_valid=4'b0010 -> req_ready=0 and out_bus={1,0xAB} held; on out_ready=1 source 1 granted same cycle.
REQ-032 SHALL verify: flush with out_valid=1 and req_valid=4'b0100, out_ready=1 -> req_ready=0; next cycle out_bus[DATA_W]=0, rr_ptr unchanged.
REQ-033 SHALL verify: reset asserted while out_valid=1, out_ready=0 -> next cycle out_bus=0, out_tag=0, subsequent first grant honours rr_ptr=0.
REQ-034 SHALL verify: req_valid=4'b1000 only, rr_ptr=1 -> source 3 granted, rr_ptr becomes 0 (wrap-around).

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter of functional-unit results onto a single registered common data bus.
// One cycle from grant to out_bus; grants are withheld while the held entry is stalled by out_ready low, or during flush/reset.
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req_valid,
  input  logic [NUM_SRC*DATA_W-1:0]  req_data,
  input  logic [NUM_SRC*TAG_W-1:0]   req_tag,
  output logic [NUM_SRC-1:0]         req_ready,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic [DATA_W:0]            out_bus,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic              out_valid;
  logic [DATA_W-1:0] value;
  logic [TAG_W-1:0]  tag;
  logic [PTR_W-1:0]  rr_ptr;

  logic              accept;
  logic              found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  next_ptr;
  logic [DATA_W-1:0] sel_data;
  logic [TAG_W-1:0]  sel_tag;

  // Reset gates the grant here so no source believes it was consumed during reset.
  assign accept = (!out_valid || out_ready) && !flush && !reset;

  // Scan sources starting at rr_ptr; the first requester found wins.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    sel_data = '0;
    sel_tag  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NUM_SRC;
      if (!found && req_valid[j]) begin
        found    = 1'b1;
        gnt_idx  = PTR_W'(j);
        sel_data = req_data[j*DATA_W +: DATA_W];
        sel_tag  = req_tag[j*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept && found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    if (gnt_idx == PTR_W'(NUM_SRC - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      value     <= '0;
      tag       <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      if (found) begin
        out_valid <= 1'b1;
        value     <= sel_data;
        tag       <= sel_tag;
        rr_ptr    <= next_ptr;
      end else begin
        // Entry drained with nothing to replace it; payload bits are left as-is.
        out_valid <= 1'b0;
      end
    end
  end

  assign out_bus = {out_valid, value};
  assign out_tag = tag;

endmodule
